// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held for the whole CYC of the
// granted master, with a stalled-strobe watchdog that aborts the transfer.
module wb_arbiter #(
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_SEL_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
    input  logic                     m0_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_cyc_i,
    output logic                     m0_ack_o,
    output logic                     m0_err_o,
    output logic [WB_DATA_WIDTH-1:0] m0_data_o,

    input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
    input  logic                     m1_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
    input  logic                     m1_stb_i,
    input  logic                     m1_cyc_i,
    output logic                     m1_ack_o,
    output logic                     m1_err_o,
    output logic [WB_DATA_WIDTH-1:0] m1_data_o,

    output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
    output logic [WB_DATA_WIDTH-1:0] s_data_o,
    output logic                     s_we_o,
    output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
    output logic                     s_stb_o,
    output logic                     s_cyc_o,
    input  logic                     s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] s_data_i,

    output logic [1:0]               grant_o,
    output logic                     timeout_o,
    input  logic                     timeout_clr_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic        r_timeout;
    logic        w_set;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == IDLE && w_next == GNT0) begin
                r_last <= 1'b0;
            end else if (r_state == IDLE && w_next == GNT1) begin
                r_last <= 1'b1;
            end
            // A new abort outranks a clear requested in the same cycle.
            if (w_set) begin
                r_timeout <= 1'b1;
            end else if (timeout_clr_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign timeout_o = r_timeout;

    always_comb begin
        s_addr_o   = '0;
        s_data_o   = '0;
        s_we_o     = 1'b0;
        s_sel_o    = '0;
        s_stb_o    = 1'b0;
        s_cyc_o    = 1'b0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_data_o  = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_data_o  = '0;
        grant_o    = 2'b00;
        w_next     = r_state;
        w_cnt_next = '0;
        w_set      = 1'b0;

        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_next = r_last ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    w_next = GNT0;
                end else if (m1_cyc_i) begin
                    w_next = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (r_state == GNT0) begin
                    s_addr_o  = m0_addr_i;
                    s_data_o  = m0_data_i;
                    s_we_o    = m0_we_i;
                    s_sel_o   = m0_sel_i;
                    s_stb_o   = m0_stb_i;
                    s_cyc_o   = m0_cyc_i;
                    m0_ack_o  = s_ack_i;
                    m0_data_o = s_data_i;
                    grant_o   = 2'b01;
                end else begin
                    s_addr_o  = m1_addr_i;
                    s_data_o  = m1_data_i;
                    s_we_o    = m1_we_i;
                    s_sel_o   = m1_sel_i;
                    s_stb_o   = m1_stb_i;
                    s_cyc_o   = m1_cyc_i;
                    m1_ack_o  = s_ack_i;
                    m1_data_o = s_data_i;
                    grant_o   = 2'b10;
                end
                // An ACK in the expiring cycle keeps the transfer alive.
                if (!s_cyc_o) begin
                    w_next = IDLE;
                end else if (s_stb_o && !s_ack_i) begin
                    if (r_cnt == LP_LIMIT) begin
                        w_next = ABORT;
                        w_set  = 1'b1;
                    end else if (r_cnt != 16'hFFFF) begin
                        w_cnt_next = r_cnt + 16'd1;
                    end else begin
                        w_cnt_next = r_cnt;
                    end
                end
            end
            ABORT: begin
                m0_err_o = ~r_last;
                m1_err_o = r_last;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: per-master expectation queues filled when a
// beat is driven, drained when the arbiter returns ACK to that master.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
    logic [31:0] m0_data_i = '0, m1_data_i = '0;
    logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
    logic        m0_stb_i = 1'b0, m1_stb_i = 1'b0;
    logic        m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_data_o, m1_data_o;
    logic [31:0] s_addr_o, s_data_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i = 1'b0;
    logic [31:0] s_data_i = '0;
    logic [1:0]  grant_o;
    logic        timeout_o;
    logic        timeout_clr_i = 1'b0;

    wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_data_o(m0_data_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_data_o(m1_data_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i), .s_data_i(s_data_i),
        .grant_o(grant_o), .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [1:0]  glog[$];
    logic [1:0]  prev_g = 2'b00;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_err0 = 0;
    int          n_err1 = 0;
    int unsigned slv_lat = 1;
    bit          slv_en = 1'b1;
    int unsigned wcnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Slave: ACKs slv_lat+1 clocks after it first samples a strobe.
    always @(posedge clk_i) begin
        if (s_cyc_o && s_stb_o && !s_ack_i && slv_en) begin
            if (wcnt == slv_lat) begin
                s_ack_i  <= 1'b1;
                s_data_i <= exp_rd(s_addr_o);
                wcnt     <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            s_ack_i <= 1'b0;
            wcnt    <= 0;
        end
    end

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            prev_g = 2'b00;
        end else begin
            if (m0_ack_o) begin
                if (sb0.size() == 0) check("m0_unexpected_ack", 64'(1), 64'(0));
                else begin
                    e = sb0.pop_front();
                    if (e.we) begin
                        check("m0_wdata", 64'(s_data_o), 64'(e.data));
                        check("m0_we", 64'(s_we_o), 64'(1));
                    end else check("m0_rdata", 64'(m0_data_o), 64'(e.data));
                end
            end
            if (m1_ack_o) begin
                if (sb1.size() == 0) check("m1_unexpected_ack", 64'(1), 64'(0));
                else begin
                    e = sb1.pop_front();
                    if (e.we) begin
                        check("m1_wdata", 64'(s_data_o), 64'(e.data));
                        check("m1_we", 64'(s_we_o), 64'(1));
                    end else check("m1_rdata", 64'(m1_data_o), 64'(e.data));
                end
            end
            if (grant_o == 2'b01) check("m1_quiet", 64'({m1_ack_o, m1_err_o, m1_data_o}), 64'(0));
            if (grant_o == 2'b10) check("m0_quiet", 64'({m0_ack_o, m0_err_o, m0_data_o}), 64'(0));
            if (grant_o == 2'b11) check("gnt_onehot", 64'(grant_o), 64'(1));
            if (grant_o != 2'b00 && prev_g != 2'b00) check("gnt_switch", 64'(grant_o), 64'(prev_g));
            if (grant_o != 2'b00 && grant_o != prev_g) glog.push_back(grant_o);
            if (m0_err_o) n_err0++;
            if (m1_err_o) n_err1++;
            prev_g = grant_o;
        end
    end

    task automatic drive_m(input int id, input logic act, input logic [31:0] a,
                           input logic we, input logic [31:0] d);
        if (id == 0) begin
            m0_cyc_i = act; m0_stb_i = act; m0_addr_i = a; m0_we_i = we; m0_data_i = d;
            m0_sel_i = act ? 4'hF : 4'h0;
        end else begin
            m1_cyc_i = act; m1_stb_i = act; m1_addr_i = a; m1_we_i = we; m1_data_i = d;
            m1_sel_i = act ? 4'hF : 4'h0;
        end
    endtask

    function automatic logic ack_of(input int id);
        return (id == 0) ? m0_ack_o : m1_ack_o;
    endfunction

    task automatic do_xfer(input int id, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            logic [31:0] a;
            exp_t        e;
            int          t;
            a = addr + 32'(4 * b);
            e.we = we;
            e.data = we ? (wdata + 32'(b)) : exp_rd(a);
            drive_m(id, 1'b1, a, we, e.data);
            if (id == 0) sb0.push_back(e);
            else sb1.push_back(e);
            t = 0;
            do begin
                @(negedge clk_i);
                t++;
            end while (!ack_of(id) && t < 100);
            check(id == 0 ? "m0_ack_seen" : "m1_ack_seen", 64'(ack_of(id)), 64'(1));
            @(posedge clk_i); #1;
        end
        drive_m(id, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic wait_grant(input logic [1:0] g, input string tag);
        int t = 0;
        while (grant_o != g && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        check(tag, 64'(grant_o), 64'(g));
    endtask

    task automatic check_glog(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                              input logic [1:0] e2, input logic [1:0] e3, input int n);
        logic [1:0] ex[4];
        ex = '{e0, e1, e2, e3};
        check({tag, "_count"}, 64'(glog.size()), 64'(n));
        for (int i = 0; i < n && i < glog.size(); i++) check(tag, 64'(glog[i]), 64'(ex[i]));
        glog.delete();
    endtask

    task automatic reset_pulse();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    task automatic count_stb(output int n);
        int t = 0;
        n = 0;
        while (!s_stb_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        while (s_stb_o && n < 20) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    initial begin
        int n;
        int t;
        // Reset: masters driving must not leak through while reset is held.
        drive_m(0, 1'b1, 32'h1234_5678, 1'b1, 32'hCAFE_0000);
        @(negedge clk_i);
        check("rst_grant", 64'(grant_o), 64'(0));
        check("rst_s_cyc", 64'({s_cyc_o, s_stb_o}), 64'(0));
        check("rst_s_addr", 64'(s_addr_o), 64'(0));
        check("rst_timeout", 64'(timeout_o), 64'(0));
        check("rst_m0", 64'({m0_ack_o, m0_err_o}), 64'(0));
        drive_m(0, 1'b0, '0, 1'b0, '0);
        @(posedge clk_i); #1 rst_i = 1'b1;

        // m0 single read with one cycle of arbitration latency.
        @(posedge clk_i); #1;
        glog.delete();
        fork
            do_xfer(0, 32'h10, 1'b0, '0, 1);
            begin
                @(negedge clk_i) check("t1_gnt_latency", 64'(grant_o), 64'(0));
                @(negedge clk_i) check("t1_gnt", 64'(grant_o), 64'(1));
            end
        join
        check_glog("t1_glog", 2'b01, 2'b00, 2'b00, 2'b00, 1);

        // Simultaneous repeated requests after reset alternate m0, m1, m0, m1.
        reset_pulse();
        @(posedge clk_i); #1;
        glog.delete();
        fork
            begin
                do_xfer(0, 32'h100, 1'b0, '0, 1);
                @(posedge clk_i); #1;
                do_xfer(0, 32'h104, 1'b0, '0, 1);
            end
            begin
                do_xfer(1, 32'h200, 1'b0, '0, 1);
                @(posedge clk_i); #1;
                do_xfer(1, 32'h204, 1'b0, '0, 1);
            end
        join
        repeat (2) @(negedge clk_i);
        check_glog("t2_glog", 2'b01, 2'b10, 2'b01, 2'b10, 4);

        // Held grant: m1 4-beat write burst; m0 requests from the first beat.
        @(posedge clk_i); #1;
        fork
            do_xfer(1, 32'h300, 1'b1, 32'h1, 4);
            begin
                wait_grant(2'b10, "t3_m1_gnt");
                @(posedge clk_i); #1;
                do_xfer(0, 32'h400, 1'b0, '0, 1);
            end
        join
        repeat (2) @(negedge clk_i);
        check_glog("t3_glog", 2'b10, 2'b01, 2'b00, 2'b00, 2);

        // Timeout: slave never ACKs; 8 strobe cycles then one ABORT cycle.
        slv_en = 1'b0;
        @(posedge clk_i); #1;
        drive_m(0, 1'b1, 32'h500, 1'b0, '0);
        count_stb(n);
        check("t4_stb_cycles", 64'(n), 64'(8));
        check("t4_abort_err", 64'({m0_err_o, m0_ack_o}), 64'(2'b10));
        check("t4_abort_s_cyc", 64'(s_cyc_o), 64'(0));
        check("t4_abort_timeout", 64'(timeout_o), 64'(1));
        check("t4_abort_m1", 64'(m1_err_o), 64'(0));
        @(posedge clk_i); #1;
        drive_m(0, 1'b0, '0, 1'b0, '0);
        repeat (3) @(negedge clk_i);
        check("t4_sticky", 64'(timeout_o), 64'(1));
        check("t4_err_count", 64'(n_err0), 64'(1));
        @(posedge clk_i); #1 timeout_clr_i = 1'b1;
        @(negedge clk_i) check("t4_clr_pending", 64'(timeout_o), 64'(1));
        @(posedge clk_i); #1 timeout_clr_i = 1'b0;
        @(negedge clk_i) check("t4_cleared", 64'(timeout_o), 64'(0));

        // ACK on the 8th stalled cycle wins over the watchdog.
        slv_en = 1'b1;
        slv_lat = 6;
        @(posedge clk_i); #1;
        fork
            do_xfer(0, 32'h520, 1'b0, '0, 1);
            begin
                t = 0;
                while (!s_stb_o && t < 50) begin
                    @(negedge clk_i);
                    t++;
                end
                n = 0;
                while (s_stb_o && !m0_ack_o && n < 20) begin
                    n++;
                    @(negedge clk_i);
                end
                check("t4v_stall_cycles", 64'(n), 64'(7));
            end
        join
        repeat (2) @(negedge clk_i);
        check("t4v_no_err", 64'(n_err0), 64'(1));
        check("t4v_no_timeout", 64'(timeout_o), 64'(0));
        slv_lat = 1;

        // m1 timeout while clear is held: set wins, clear lands on the next clock.
        slv_en = 1'b0;
        @(posedge clk_i); #1;
        timeout_clr_i = 1'b1;
        drive_m(1, 1'b1, 32'h540, 1'b0, '0);
        count_stb(n);
        check("t4c_stb_cycles", 64'(n), 64'(8));
        check("t4c_m1_err", 64'({m1_err_o, m0_err_o}), 64'(2'b10));
        check("t4c_set_wins", 64'(timeout_o), 64'(1));
        @(posedge clk_i); #1;
        drive_m(1, 1'b0, '0, 1'b0, '0);
        @(negedge clk_i) check("t4c_cleared", 64'(timeout_o), 64'(0));
        timeout_clr_i = 1'b0;
        check("t4c_err_count", 64'(n_err1), 64'(1));

        // Asynchronous reset mid-transfer in GNT1.
        @(posedge clk_i); #1;
        drive_m(1, 1'b1, 32'h600, 1'b0, '0);
        wait_grant(2'b10, "t5_m1_gnt");
        #2 rst_i = 1'b0;
        #1;
        check("t5_async_cyc_stb", 64'({s_cyc_o, s_stb_o}), 64'(0));
        check("t5_async_grant", 64'(grant_o), 64'(0));
        check("t5_async_m1", 64'({m1_ack_o, m1_err_o}), 64'(0));
        drive_m(1, 1'b0, '0, 1'b0, '0);
        slv_en = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        glog.delete();
        @(posedge clk_i); #1;
        fork
            do_xfer(0, 32'h700, 1'b0, '0, 1);
            do_xfer(1, 32'h800, 1'b0, '0, 1);
        join
        repeat (2) @(negedge clk_i);
        check_glog("t5_glog", 2'b01, 2'b10, 2'b00, 2'b00, 2);

        // Back-to-back m0: exactly one IDLE cycle between the two grants.
        @(posedge clk_i); #1;
        do_xfer(0, 32'h900, 1'b0, '0, 1);
        @(negedge clk_i) check("t6_still_gnt", 64'(grant_o), 64'(1));
        @(posedge clk_i); #1;
        fork
            do_xfer(0, 32'h904, 1'b0, '0, 1);
            begin
                @(negedge clk_i) check("t6_idle_gap", 64'(grant_o), 64'(0));
                @(negedge clk_i) check("t6_regrant", 64'(grant_o), 64'(1));
            end
        join

        repeat (3) @(negedge clk_i);
        check("sb0_drained", 64'(sb0.size()), 64'(0));
        check("sb1_drained", 64'(sb1.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the SoC bus between the CPU (master 0) and the external debug/loader master (master 1).
- Replaces the static master-select pin with round-robin arbitration.
- The grant is held for the whole CYC of the granted master.
- A watchdog aborts slave transfers that never ACK and reports them through a sticky flag and an error response.

Parameters:
- WB_DATA_WIDTH, 32, data bus width
- WB_ADDR_WIDTH, 32, address bus width
- WB_SEL_WIDTH, 4, byte-select width
- TIMEOUT_CYCLES, 255, stalled-strobe cycles before abort (1..65535; counter is 16 bits)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- m0_addr_i  in  WB_ADDR_WIDTH  master 0 address
- m0_data_i  in  WB_DATA_WIDTH  master 0 write data
- m0_we_i  in  1  master 0 write enable
- m0_sel_i  in  WB_SEL_WIDTH  master 0 byte selects
- m0_stb_i  in  1  master 0 strobe
- m0_cyc_i  in  1  master 0 cycle
- m0_ack_o  out  1  master 0 acknowledge
- m0_err_o  out  1  master 0 error (timeout abort)
- m0_data_o  out  WB_DATA_WIDTH  master 0 read data
- m1_*  (same nine ports as m0_*)  master 1, external
- s_addr_o  out  WB_ADDR_WIDTH  slave address
- s_data_o  out  WB_DATA_WIDTH  slave write data
- s_we_o  out  1  slave write enable
- s_sel_o  out  WB_SEL_WIDTH  slave byte selects
- s_stb_o  out  1  slave strobe
- s_cyc_o  out  1  slave cycle
- s_ack_i  in  1  slave acknowledge
- s_data_i  in  WB_DATA_WIDTH  slave read data
- grant_o  out  2  one-hot current grant; 00 = none
- timeout_o  out  1  sticky timeout flag
- timeout_clr_i  in  1  clears timeout_o

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=IDLE, last=1 (so master 0 wins the first tie), counter=0, timeout_o=0.
  - All outputs are 0 while reset is held. Reset during a transfer drops s_cyc_o/s_stb_o immediately.
- States are IDLE, GNT0, GNT1, ABORT.
- IDLE:
  - No grant; all s_* outputs and all m*_ack/err/data outputs are 0.
  - If only one master has cyc=1, go to that master's GNT state.
  - If both have cyc=1, grant the master that is not `last`.
  - Grant takes effect the cycle after the request is sampled: one cycle of arbitration latency.
- GNTn:
  - grant_o is one-hot n.
  - s_* outputs are a combinational copy of master n's inputs.
  - mn_ack_o = s_ack_i and mn_data_o = s_data_i, both combinational with zero added latency.
  - The other master sees ack=0, err=0, data=0.
  - Entering GNTn sets last=n.
  - mn_cyc_i=0 returns to IDLE. There is always at least one IDLE cycle between grants, including back-to-back requests from the same master.
  - Multiple STB beats within one CYC all stay on master n.
- Watchdog:
  - In GNTn, the counter increments each cycle with s_stb_o=1 and s_ack_i=0.
  - It clears on s_ack_i=1, on stb=0, and on leaving GNTn.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ACK that cycle, the next state is ABORT.
- ABORT (exactly one cycle):
  - s_cyc_o=s_stb_o=0.
  - mn_err_o=1 and mn_ack_o=0 for the master that was granted.
  - timeout_o is set to 1.
  - Next state is IDLE. The master must drop cyc; if it keeps cyc high, it is re-arbitrated from IDLE normally.
- An ACK arriving in the same cycle the count would expire wins: the ACK passes through and there is no abort.
- timeout_o:
  - Holds until timeout_clr_i=1; clearing takes effect on the next clock.
  - If set and clear occur in the same cycle, set wins.
- A slave ACK arriving in IDLE or ABORT is ignored and routed to no master.
- Counter width is 16 bits and saturates, so it never wraps.

Test Plan:
- m0 single read: m0 cyc/stb with addr 0x0000_0010; slave ACKs 2 cycles after s_stb_o with data 0xDEAD_BEEF.
  - grant_o=01 one cycle after request.
  - m0_ack_o and m0_data_o=0xDEAD_BEEF in the same cycle as s_ack_i.
  - m1_ack_o=0 throughout.
- Simultaneous requests after reset: both masters raise cyc in the same cycle and repeat.
  - Grants go m0, m1, m0, m1.
  - Each grant is separated by one IDLE cycle with grant_o=00.
- Held grant: m1 performs a 4-beat cyc (writes 0x1..0x4) while m0 requests from beat 1.
  - All 4 beats reach the slave from m1 with s_we_o=1 and s_data_o matching.
  - m0 is granted only after m1 drops cyc plus one IDLE cycle.
- Timeout: TIMEOUT_CYCLES=8; m0 strobes and the slave never ACKs.
  - s_stb_o is high for 8 cycles.
  - Then one ABORT cycle: m0_err_o=1, s_cyc_o=0, timeout_o=1.
  - timeout_o stays 1 until timeout_clr_i is pulsed.
  - Variant: ACK arrives on the 8th stalled cycle; no error is raised and timeout_o stays 0.
- Reset mid-transfer: assert rst_i low asynchronously (between clock edges) during GNT1.
  - s_cyc_o, s_stb_o and grant_o drop to 0 without waiting for a clock.
  - After release, a tie is granted to m0.
- Back-to-back same master: m0 drops cyc for one cycle, then re-requests while m1 stays idle.
  - m0 is re-granted after exactly one IDLE cycle.
